// File: rtl/imem_loader_if.sv
// Byte-stream loader bus: start/length request, byte stream in, imem write port and core control out.
// master = byte source / host side, slave = the loader.
interface imem_loader_if #(
  parameter int IMEM_WORDS = 64
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic          start;
  logic [AW:0]   len_words;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, len_words, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );

  modport slave (
    input  start, len_words, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads little-endian words from a byte stream into imem, holding the core in reset until done (IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte).
// Latency: 5 cycles per word; done on cycle 5N (5N+1 with checksum) after the first accepted byte.
// Backpressure: in_ready is a pure state decode; in_valid low stalls indefinitely.
module imem_loader #(
  parameter int IMEM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int AW = $clog2(IMEM_WORDS);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(IMEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        len_legal;
  logic        accept;
  logic        in_ready;
  logic [AW:0] last_idx;

  assign len_legal = (bus.len_words != '0) && (bus.len_words <= LEN_MAX);
  assign last_idx  = len_q - (AW+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_LOAD) || (state_q == S_CHK);
  assign bus.busy = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CHK);
`else
  assign in_ready = (state_q == S_LOAD);
  assign bus.busy = (state_q == S_LOAD) || (state_q == S_WRITE);
`endif
  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.start) begin
          if (len_legal) begin
            len_d      = bus.len_words;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            err_d      = 1'b0;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          csum_d     = csum_q ^ bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Capture the write port here so it is registered during WRITE.
            addr_d  = 32'({word_cnt_q, 2'b00});
            wdata_d = {bus.in_data, word_q[23:0]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        if ({1'b0, word_cnt_q} < last_idx) begin
          state_d = S_LOAD;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_RUN) && (state_q != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  // A legal restart from RUN re-asserts core reset in the same cycle.
  assign bus.core_rst   = (state_q != S_RUN) || (bus.start && len_legal);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes are queued at stimulus time and
// checked by an independent monitor whenever the write strobe is seen.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.IMEM_WORDS(64)) bus ();
  imem_loader #(.IMEM_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_acc = 0;
  bit first_pending = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        chk("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
      end
      chk("in_ready_in_write", 64'(bus.in_ready), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit check_restart);
    bus.start     = 1'b1;
    bus.len_words = 7'(len);
    @(negedge clk);
    if (check_restart) chk("core_rst_on_restart", 64'(bus.core_rst), 64'd1);
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  t = 0;
    bit  got = 1'b0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!got && t < 50) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        if (first_pending) begin
          first_acc     = cyc;
          first_pending = 1'b0;
        end
      end
      step();
      t++;
    end
    if (!got) chk("byte_accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bq[$], input int gap);
    first_pending = 1'b1;
    foreach (bq[i]) send_byte(bq[i], (i == 0) ? 0 : gap);
  endtask

  task automatic wait_done(input bit check_lat, input int exp_lat);
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 80) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        if (check_lat) chk("done_latency", 64'(cyc - first_acc), 64'(exp_lat));
        chk("core_rst_released", 64'(bus.core_rst), 64'd0);
      end
      step();
      t++;
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"},
        64'({bus.in_ready, bus.imem_we, bus.core_rst, bus.busy, bus.done, bus.err}),
        64'b001000);
    chk({tag, "_bus"}, {bus.imem_addr, bus.imem_wdata}, 64'd0);
  endtask

  logic [7:0] basic[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
  logic [7:0] dead[$]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.len_words = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;

    // Reset with random noise on the inputs
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.start     = 1'($urandom_range(0, 1));
      bus.len_words = 7'd2;
      bus.in_data   = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_reset_vals("reset");
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();

    // Illegal lengths
    do_start(0, 1'b0);
    @(negedge clk);
    chk("len0_err", 64'({bus.err, bus.in_ready, bus.busy, bus.core_rst}), 64'b1001);
    step();
    do_start(65, 1'b0);
    @(negedge clk);
    chk("len65_err", 64'({bus.err, bus.in_ready, bus.busy, bus.core_rst}), 64'b1001);
    step();

    // Basic load, no gaps
    exp_q.push_back({32'h0000_0000, 32'h0050_0513});
    exp_q.push_back({32'h0000_0004, 32'h00A0_0593});
    do_start(2, 1'b0);
    @(negedge clk);
    chk("err_cleared", 64'({bus.err, bus.busy, bus.core_rst}), 64'b011);
    step();
    send_bytes(basic, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h70, 0);
`endif
    wait_done(1'b1, 10 + LAT_EXTRA);

    // Same words with 3-cycle gaps, restarted from RUN
    exp_q.push_back({32'h0000_0000, 32'h0050_0513});
    exp_q.push_back({32'h0000_0004, 32'h00A0_0593});
    do_start(2, 1'b1);
    send_bytes(basic, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h70, 3);
`endif
    wait_done(1'b0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum keeps the core in reset
    begin
      bit seen_done = 1'b0;
      exp_q.push_back({32'h0000_0000, 32'h0050_0513});
      exp_q.push_back({32'h0000_0004, 32'h00A0_0593});
      do_start(2, 1'b1);
      send_bytes(basic, 0);
      send_byte(8'h71, 0);
      repeat (20) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen_done = 1'b1;
        step();
      end
      chk("bad_csum_no_done", 64'(seen_done), 64'd0);
      @(negedge clk);
      chk("bad_csum_state", 64'({bus.err, bus.core_rst, bus.busy, bus.in_ready}), 64'b1100);
      step();
    end
`endif

    // Reset mid-load discards the partial word
    do_start(1, 1'b0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midload_reset");
    step();

    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    do_start(1, 1'b0);
    send_bytes(dead, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h22, 0);
`endif
    wait_done(1'b1, 5 + LAT_EXTRA);

    repeat (5) step();
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
